count_arbiter: RTL and testbench
================================

COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the counter (2..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 7, width of the count and terminal values.
REQ-003 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  NUM_REQ  per-requester level request for one count run.
REQ-006 SHALL have port cnt_val_i  input  NUM_REQ*CNT_WIDTH  per-requester terminal value; requester k uses slice [k*CNT_WIDTH +: CNT_WIDTH].
REQ-007 SHALL have port abort_i  input  1  terminates the active run.
REQ-008 SHALL have port grant_o  output  NUM_REQ  one-hot owner of the counter; zero when idle.
REQ-009 SHALL have port done_o  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-010 SHALL have port busy_o  output  1  high in RUN and DONE.
REQ-011 SHALL have port cnt_o  output  CNT_WIDTH  current count value.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE in a registered FSM.
REQ-013 In IDLE with any req_i bit set, SHALL select the winner round-robin, searching from (last winner + 1) mod NUM_REQ upward with wrap-around.
REQ-014 On the selection edge, SHALL register the winner one-hot and its cnt_val_i slice, clear the count to 0 and enter RUN.
REQ-015 In RUN, SHALL increment the count by 1 per cycle and enter DONE on the cycle after the count equals the captured value.
REQ-016 For a request seen in IDLE at cycle T with value V: RUN SHALL span cycles T+1..T+1+V, DONE SHALL be at T+2+V and IDLE at T+3+V.
REQ-017 V=0 SHALL produce exactly one RUN cycle.
REQ-018 V=2^CNT_WIDTH-1 SHALL complete without count wrap.
REQ-019 In DONE, SHALL pulse done_o at the owner's bit only, update the last-winner pointer to the owner and return to IDLE.
REQ-020 grant_o SHALL equal the registered owner throughout RUN and DONE and SHALL be zero in IDLE.
REQ-021 cnt_val_i and req_i changes during RUN or DONE SHALL be ignored.
REQ-022 Requests SHALL be sampled only in IDLE, so the earliest next grant after a DONE cycle is the IDLE cycle that follows it.
REQ-023 abort_i high in RUN SHALL return to IDLE on the next edge with no done_o pulse and no pointer update.
REQ-024 abort_i SHALL be ignored in IDLE and DONE.
REQ-025 abort_i and the terminal-count match in the same RUN cycle SHALL resolve as abort (no DONE).
REQ-026 cnt_o SHALL hold its last value in IDLE and DONE.

Reset
REQ-027 Asserting rst_n SHALL immediately force state IDLE, grant_o=0, done_o=0, busy_o=0, cnt_o=0, captured value 0 and last-winner pointer NUM_REQ-1, so that requester 0 has first priority.
REQ-028 Reset asserted mid-run SHALL drop the run with no done_o pulse.

Structure
REQ-029 The state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default CNT_WIDTH SHALL reside in a shared package used by all counter-controller blocks.
REQ-030 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and pointer; output one-hot winner), instantiated once.

Verification
REQ-031 Reset, then req_i=4'b0001, value 3 at T -> grant_o=0001 over T+1..T+5, cnt_o 0,1,2,3 over T+1..T+4, done_o=0001 only at T+5.
REQ-032 req_i=4'b1111 held, all values 0 -> grants in order 0001, 0010, 0100, 1000, 0001, each followed by one done pulse; no requester starved.
REQ-033 Value 0 then value 127 (CNT_WIDTH=7) -> one RUN cycle for the first; 128 RUN cycles and cnt_o peaking at 127 without wrap for the second.
REQ-034 abort_i in the third RUN cycle of a value-10 run -> IDLE next edge, no done_o, next grant chosen with an unchanged pointer.
REQ-035 rst_n asserted mid-RUN -> all outputs 0 asynchronously; after release, a req_i=4'b1010 request is granted to requester 1.
REQ-036 cnt_val_i changed from 5 to 1 during RUN -> run still completes after 6 RUN cycles.

Source files
------------

// File: rtl/count_arbiter_pkg.sv
// Shared definitions for the counter-controller blocks: FSM encodings,
// default count width and a one-hot to index helper.
package count_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEFAULT_CNT_WIDTH = 7;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/count_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from ptr+1 upward with
// wrap-around and returns the first requester found as a one-hot vector.
module rr_pick
    import count_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic found;

    // Walk the candidates in priority order, offset 1 being the highest.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[k] && (k == ((int'(ptr) + off) % NUM_REQ))) begin
                    winner[k] = 1'b1;
                    found     = 1'b1;
                end else begin
                    found = found;
                end
            end
        end
    end

endmodule

// File: rtl/count_arbiter.sv
// Shared up-counter arbitrated round-robin among NUM_REQ requesters; each
// run counts 0..V for the owner's terminal value V, then pulses done.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]   cnt_val_i,
    input  logic                           abort_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic                           busy_o,
    output logic [CNT_WIDTH-1:0]           cnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                 state_r;
    logic [NUM_REQ-1:0]     grant_r;
    logic [NUM_REQ-1:0]     done_r;
    logic                   busy_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cap_r;
    logic [PTR_W-1:0]       ptr_r;

    logic [NUM_REQ-1:0]     pick_s;
    logic [CNT_WIDTH-1:0]   cap_sel_s;
    logic [7:0]             grant_ext_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req_i),
        .ptr    (ptr_r),
        .winner (pick_s)
    );

    assign grant_ext_s = 8'(grant_r);

    // Terminal value of the requester the picker is selecting this cycle.
    always_comb begin
        cap_sel_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_s[k]) begin
                cap_sel_s = cnt_val_i[k*CNT_WIDTH +: CNT_WIDTH];
            end else begin
                cap_sel_s = cap_sel_s;
            end
        end
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            done_r  <= '0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
            cap_r   <= '0;
            ptr_r   <= PTR_W'(NUM_REQ - 1);
        end else begin
            done_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_r <= pick_s;
                        cap_r   <= cap_sel_s;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Abort wins over a terminal match; the count is left as is.
                    if (abort_i) begin
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == cap_r) begin
                        done_r  <= grant_r;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    ptr_r   <= PTR_W'(oh_to_idx(grant_ext_s));
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o = grant_r;
    assign done_o  = done_r;
    assign busy_o  = busy_r;
    assign cnt_o   = cnt_r;

endmodule

// File: tb/tb_count_arbiter.sv
// Scoreboard bench for count_arbiter: each issued run pushes its expected
// owner and terminal value; a monitor checks every done pulse against it.
module tb_count_arbiter;

    localparam int NR = 4;
    localparam int CW = 7;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*CW-1:0]  cnt_val;
    logic              abort;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     vals [NR];

    typedef struct {
        logic [NR-1:0] owner;
        int            v;
    } exp_t;

    exp_t exp_q[$];
    int   total_checks = 0;
    int   passed_checks = 0;
    int   run_len = 0;
    int   peak = 0;

    count_arbiter #(.NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .cnt_val_i (cnt_val),
        .abort_i   (abort),
        .grant_o   (grant),
        .done_o    (done),
        .busy_o    (busy),
        .cnt_o     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cnt_val = {vals[3], vals[2], vals[1], vals[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input int v0, input int v1, input int v2, input int v3);
        vals[0] = 7'(v0);
        vals[1] = 7'(v1);
        vals[2] = 7'(v2);
        vals[3] = 7'(v3);
    endtask

    task automatic push(input logic [NR-1:0] owner, input int v);
        exp_t e;
        e.owner = owner;
        e.v     = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout_busy", 32'(busy), 32'd0);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done != '0) begin
            if (exp_q.size() == 0) begin
                total_checks++;
                $display("FAIL unexpected_done: got %b, expected no pulse at %0t", done, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_owner", 32'(done), 32'(e.owner));
                check("grant_in_done", 32'(grant), 32'(e.owner));
                check("run_cycles", 32'(run_len), 32'(e.v + 1));
                check("cnt_in_done", 32'(cnt), 32'(e.v));
                check("cnt_peak", 32'(peak), 32'(e.v));
            end
            run_len = 0;
            peak    = 0;
        end else if (busy) begin
            run_len++;
            if (int'(cnt) > peak) peak = int'(cnt);
        end else begin
            run_len = 0;
            peak    = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dones;
        rst_n = 1'b0;
        req   = '0;
        abort = 1'b0;
        set_vals(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cnt", 32'(cnt), 32'd0);

        // Single run for requester 0, value 3.
        req = 4'b0001;
        set_vals(3, 0, 0, 0);
        push(4'b0001, 3);
        tick();
        req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("run1_grant", 32'(grant), 32'b0001);
            check("run1_cnt", 32'(cnt), 32'(k));
        end
        @(negedge clk);
        check("run1_done_grant", 32'(grant), 32'b0001);
        check("run1_done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("run1_idle_grant", 32'(grant), 32'd0);
        check("run1_idle_busy", 32'(busy), 32'd0);
        check("run1_idle_cnt", 32'(cnt), 32'd3);

        // Fresh reset, then all four requesting with value 0: full rotation.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_vals(0, 0, 0, 0);
        push(4'b0001, 0);
        push(4'b0010, 0);
        push(4'b0100, 0);
        push(4'b1000, 0);
        push(4'b0001, 0);
        req = 4'b1111;
        dones = 0;
        for (int i = 0; i < 40 && dones < 5; i++) begin
            @(negedge clk);
            if (done != '0) dones++;
        end
        req = 4'b0000;
        check("rotation_dones", 32'(dones), 32'd5);
        wait_idle(10);

        // Shortest and longest runs.
        req = 4'b0001;
        set_vals(0, 0, 0, 0);
        push(4'b0001, 0);
        tick();
        req = 4'b0000;
        wait_idle(10);
        req = 4'b0001;
        set_vals(127, 0, 0, 0);
        push(4'b0001, 127);
        tick();
        req = 4'b0000;
        wait_idle(200);

        // Abort in the third RUN cycle of a value-10 run by requester 2.
        req = 4'b0100;
        set_vals(0, 0, 10, 0);
        tick();
        req = 4'b0000;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cnt_hold", 32'(cnt), 32'd2);
        // Pointer still at requester 0, so 2 beats 0.
        req = 4'b0101;
        set_vals(0, 0, 1, 0);
        push(4'b0100, 1);
        tick();
        req = 4'b0000;
        wait_idle(10);

        // Asynchronous reset in the middle of a run.
        req = 4'b0001;
        set_vals(5, 0, 0, 0);
        tick();
        req = 4'b0000;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req = 4'b1010;
        set_vals(0, 2, 0, 0);
        push(4'b0010, 2);
        tick();
        req = 4'b0000;
        wait_idle(10);

        // Abort in IDLE is ignored; value change during RUN is ignored.
        req   = 4'b0001;
        abort = 1'b1;
        set_vals(5, 0, 0, 0);
        push(4'b0001, 5);
        tick();
        abort = 1'b0;
        req   = 4'b0000;
        set_vals(1, 0, 0, 0);
        wait_idle(20);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
